mem_io_arbiter: RTL and testbench
=================================

Name: mem_io_arbiter

Overview:
- Sequences and shares the single data-side memory/IO port (memCe/memWr/memAddr/wtData/rdData, upstream of the RAM/IO address decoder) between two requesters: the CPU MEM stage (port 0) and a DMA/debug master (port 1).
- Adds per-region wait states: IO region 0x7000_0000–0x7FFF_FFFF gets IO_WAIT; all other addresses get RAM_WAIT.
- Round-robin arbitration, one outstanding access, registered bus outputs, and a CPU stall signal for the pipeline.

Parameters:
- RAM_WAIT, 0, extra cycles memCe is held for RAM addresses (0..2^CNT_W-1)
- IO_WAIT, 3, extra cycles memCe is held for IO addresses (0..2^CNT_W-1)
- CNT_W, 4, wait counter width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- cpuReq  in  1  CPU access request (level)
- cpuWr  in  1  1=write, 0=read
- cpuAddr  in  32  CPU byte address
- cpuWtData  in  32  CPU write data
- cpuAck  out  1  one-cycle completion pulse to CPU
- cpuRdData  out  32  CPU read data, valid while cpuAck=1 and held until the next CPU access completes
- cpuStall  out  1  cpuReq & ~cpuAck (combinational)
- dmaReq  in  1  DMA request (level)
- dmaWr  in  1  1=write
- dmaAddr  in  32  DMA address
- dmaWtData  in  32  DMA write data
- dmaAck  out  1  one-cycle completion pulse to DMA
- dmaRdData  out  32  DMA read data, same validity as cpuRdData
- memCe  out  1  port enable (1=enable)
- memWr  out  1  port write
- memAddr  out  32  port address
- wtData  out  32  port write data
- rdData  in  32  port read data

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; memCe, memWr, memAddr, wtData = 0; cpuAck, dmaAck = 0; cpuRdData, dmaRdData = 0; counter = 0.
  - lastGnt=DMA, so the CPU wins the first tie.
  - Reset mid-access aborts the access immediately; no ack is issued for it.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - No request: stay in IDLE with memCe=0.
  - Exactly one request: grant it.
  - Both requesting: grant the port that is not lastGnt.
  - On grant (registered at the edge):
    - memCe=1; memWr/memAddr/wtData taken from the winner; owner and lastGnt set to the winner.
    - counter = IO_WAIT if 0x7000_0000 <= addr < 0x8000_0000 (unsigned compare), else RAM_WAIT.
    - Next state: BUSY.
- BUSY:
  - memCe/memWr/memAddr/wtData are held stable; requester inputs are ignored.
  - counter != 0: decrement and stay in BUSY.
  - counter == 0: at the edge, capture rdData into the owner's RdData register (reads only; writes leave it unchanged), set the owner's Ack=1, clear memCe/memWr/memAddr/wtData to 0, go to RESP.
- RESP:
  - Owner's Ack is high for exactly this cycle; no grant is made.
  - At the edge: Ack=0, go to IDLE.
- Latency: req seen in IDLE at edge E0 -> memCe high for cycles E0+1 .. E0+1+W, with W=counter load -> Ack high for one cycle starting at E0+2+W. RAM_WAIT=0 gives a 1-cycle bus access and ack 2 cycles after grant.
- Handshake: a requester holds req and its qualifiers stable until it samples Ack=1, then deasserts req or presents a new request in the next cycle. IDLE re-samples req one cycle after RESP.
- Back-to-back throughput: each requester gets one access per W+3 cycles at most.
- Fairness with both requests permanently asserted: grants alternate CPU, DMA, CPU, …
- The address decode uses only the latched address; an address change during BUSY has no effect.
- Exactly one access is outstanding at a time; cpuAck and dmaAck are never high together.

Test Plan:
- Reset then cpuReq=1, cpuWr=0, cpuAddr=0x0000_0010, rdData=0xDEAD_BEEF, RAM_WAIT=0 -> memCe high for 1 cycle with memAddr=0x10; cpuAck pulses 2 cycles after grant; cpuRdData=0xDEAD_BEEF; cpuStall=1 until the ack cycle.
- dmaReq=1, dmaWr=1, dmaAddr=0x7000_0004, dmaWtData=0x0000_00A5, IO_WAIT=3 -> memCe=memWr=1 for 4 cycles with wtData=0xA5; dmaAck pulses once; dmaRdData unchanged.
- cpuReq and dmaReq both held high from reset, RAM addresses -> grant order CPU, DMA, CPU, DMA; acks never overlap; each ack spaced 3 cycles apart.
- Address boundary, read: 0x6FFF_FFFC -> 1-cycle memCe. 0x7FFF_FFFC -> 4 cycles. 0x8000_0000 -> 1 cycle.
- Reset mid-BUSY during an IO access: rst low in the 2nd wait cycle -> memCe=0 immediately, no ack. After release, a CPU+DMA tie grants the CPU first.
- CPU changes cpuAddr from 0x7000_0000 to 0x0000_0000 during BUSY -> memAddr stays 0x7000_0000 for the full 4 cycles.

Source files
------------

// File: rtl/mem_io_arbiter.sv
// mem_io_arbiter: round-robin sharer of the data-side memory/IO port between CPU and DMA with per-region wait states
module mem_io_arbiter #(
  parameter int RAM_WAIT = 0,
  parameter int IO_WAIT  = 3,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpuReq,
  input  logic        cpuWr,
  input  logic [31:0] cpuAddr,
  input  logic [31:0] cpuWtData,
  output logic        cpuAck,
  output logic [31:0] cpuRdData,
  output logic        cpuStall,
  input  logic        dmaReq,
  input  logic        dmaWr,
  input  logic [31:0] dmaAddr,
  input  logic [31:0] dmaWtData,
  output logic        dmaAck,
  output logic [31:0] dmaRdData,
  output logic        memCe,
  output logic        memWr,
  output logic [31:0] memAddr,
  output logic [31:0] wtData,
  input  logic [31:0] rdData
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t            state_q, state_d;
  logic              owner_q, owner_d, last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ce_q, ce_d, wr_q, wr_d;
  logic [31:0]       addr_q, addr_d, wdata_q, wdata_d;
  logic [31:0]       cpu_rd_q, cpu_rd_d, dma_rd_q, dma_rd_d;
  logic              cpu_ack_q, cpu_ack_d, dma_ack_q, dma_ack_d;
  logic              win, win_wr;
  logic [31:0]       win_addr, win_wdata;
  // pick the winner (1 = DMA): a lone requester wins, a tie goes to the port not granted last
  always_comb begin
    win       = (cpuReq && dmaReq) ? ~last_q : dmaReq;
    win_wr    = win ? dmaWr : cpuWr;
    win_addr  = win ? dmaAddr : cpuAddr;
    win_wdata = win ? dmaWtData : cpuWtData;
  end
  // next-state: grant in IDLE, count wait states in BUSY, single ack cycle in RESP
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    ce_d      = ce_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cpu_rd_d  = cpu_rd_q;
    dma_rd_d  = dma_rd_q;
    cpu_ack_d = 1'b0;
    dma_ack_d = 1'b0;
    case (state_q)
      IDLE: if (cpuReq || dmaReq) begin
        state_d = BUSY;
        ce_d    = 1'b1;
        wr_d    = win_wr;
        addr_d  = win_addr;
        wdata_d = win_wdata;
        owner_d = win;
        last_d  = win;
        cnt_d   = (win_addr[31:28] == 4'h7) ? CNT_W'(IO_WAIT) : CNT_W'(RAM_WAIT);
      end
      BUSY: if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        state_d   = RESP;
        ce_d      = 1'b0;
        wr_d      = 1'b0;
        addr_d    = '0;
        wdata_d   = '0;
        cpu_ack_d = ~owner_q;
        dma_ack_d = owner_q;
        cpu_rd_d  = (!wr_q && !owner_q) ? rdData : cpu_rd_q;
        dma_rd_d  = (!wr_q && owner_q) ? rdData : dma_rd_q;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and registered bus/response outputs; reset aborts any access in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      cnt_q     <= '0;
      ce_q      <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cpu_rd_q  <= '0;
      dma_rd_q  <= '0;
      cpu_ack_q <= 1'b0;
      dma_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      ce_q      <= ce_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cpu_rd_q  <= cpu_rd_d;
      dma_rd_q  <= dma_rd_d;
      cpu_ack_q <= cpu_ack_d;
      dma_ack_q <= dma_ack_d;
    end
  end
  assign memCe     = ce_q;
  assign memWr     = wr_q;
  assign memAddr   = addr_q;
  assign wtData    = wdata_q;
  assign cpuAck    = cpu_ack_q;
  assign dmaAck    = dma_ack_q;
  assign cpuRdData = cpu_rd_q;
  assign dmaRdData = dma_rd_q;
  assign cpuStall  = cpuReq & ~cpu_ack_q;
endmodule

// File: tb/tb_mem_io_arbiter.sv
// tb_mem_io_arbiter: directed stimulus with a transaction-level reference model and per-cycle compare
module tb_mem_io_arbiter;
  localparam int RW = 0;
  localparam int IW = 3;
  logic        clk = 1'b0, rst = 1'b0;
  logic        cpuReq = 0, cpuWr = 0, dmaReq = 0, dmaWr = 0;
  logic [31:0] cpuAddr = 0, cpuWtData = 0, dmaAddr = 0, dmaWtData = 0, rdData = 0;
  logic        cpuAck, cpuStall, dmaAck, memCe, memWr;
  logic [31:0] cpuRdData, dmaRdData, memAddr, wtData;
  int checks = 0, errors = 0, cyc = 0, ce_cnt = 0, lat;
  int ack_port[$], ack_cyc[$];

  mem_io_arbiter #(.RAM_WAIT(RW), .IO_WAIT(IW), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .cpuReq(cpuReq), .cpuWr(cpuWr), .cpuAddr(cpuAddr), .cpuWtData(cpuWtData),
    .cpuAck(cpuAck), .cpuRdData(cpuRdData), .cpuStall(cpuStall),
    .dmaReq(dmaReq), .dmaWr(dmaWr), .dmaAddr(dmaAddr), .dmaWtData(dmaWtData),
    .dmaAck(dmaAck), .dmaRdData(dmaRdData),
    .memCe(memCe), .memWr(memWr), .memAddr(memAddr), .wtData(wtData), .rdData(rdData)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  function automatic bit is_io(input logic [31:0] a);
    return (a >= 32'h7000_0000) && (a < 32'h8000_0000);
  endfunction

  // Reference model: an access occupies the bus for W+1 cycles after its grant,
  // acks in the following cycle, then the port is free for one idle sample.
  logic        m_busy, m_own, m_last, m_wr;
  int          m_t, m_w;
  logic [31:0] m_addr, m_wd, m_crd, m_drd;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 0; m_own <= 0; m_last <= 1; m_wr <= 0; m_t <= 0; m_w <= 0;
      m_addr <= 0; m_wd <= 0; m_crd <= 0; m_drd <= 0;
    end else if (!m_busy) begin
      if (cpuReq || dmaReq) begin
        m_busy <= 1;
        m_t    <= 1;
        m_own  <= (cpuReq && dmaReq) ? !m_last : dmaReq;
        m_last <= (cpuReq && dmaReq) ? !m_last : dmaReq;
        m_wr   <= dmaReq && (!cpuReq || !m_last) ? dmaWr : cpuWr;
        m_addr <= dmaReq && (!cpuReq || !m_last) ? dmaAddr : cpuAddr;
        m_wd   <= dmaReq && (!cpuReq || !m_last) ? dmaWtData : cpuWtData;
        m_w    <= is_io(dmaReq && (!cpuReq || !m_last) ? dmaAddr : cpuAddr) ? IW : RW;
      end
    end else if (m_t == m_w + 2) begin
      m_busy <= 0;
    end else begin
      m_t <= m_t + 1;
      if (m_t == m_w + 1 && !m_wr) begin
        if (m_own) m_drd <= rdData;
        else m_crd <= rdData;
      end
    end
  end

  // Compare DUT outputs with the model shortly after every rising edge
  logic e_bus, e_cack, e_dack;
  always @(posedge clk) begin
    #2;
    cyc++;
    e_bus  = m_busy && (m_t <= m_w + 1);
    e_cack = m_busy && (m_t == m_w + 2) && !m_own;
    e_dack = m_busy && (m_t == m_w + 2) && m_own;
    chk("memCe", memCe, e_bus);
    chk("memWr", memWr, e_bus && m_wr);
    chk("memAddr", memAddr, e_bus ? m_addr : 0);
    chk("wtData", wtData, e_bus ? m_wd : 0);
    chk("cpuAck", cpuAck, e_cack);
    chk("dmaAck", dmaAck, e_dack);
    chk("cpuRdData", cpuRdData, m_crd);
    chk("dmaRdData", dmaRdData, m_drd);
    chk("cpuStall", cpuStall, cpuReq && !e_cack);
    chk("ack_overlap", cpuAck && dmaAck, 0);
    if (memCe) ce_cnt++;
    if (cpuAck) begin ack_port.push_back(0); ack_cyc.push_back(cyc); end
    if (dmaAck) begin ack_port.push_back(1); ack_cyc.push_back(cyc); end
  end

  // One complete access from port p (1 = DMA); lat = negedges from request to ack
  task automatic access(input bit p, input bit wr, input logic [31:0] a, input logic [31:0] wd, output int l);
    @(negedge clk);
    ce_cnt = 0;
    if (p) begin dmaReq = 1; dmaWr = wr; dmaAddr = a; dmaWtData = wd; end
    else begin cpuReq = 1; cpuWr = wr; cpuAddr = a; cpuWtData = wd; end
    l = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (p ? dmaAck : cpuAck) begin l = i; break; end
    end
    cpuReq = 0; dmaReq = 0;
  endtask

  task automatic wait_acks(input int n);
    for (int i = 0; i < 60 && ack_port.size() < n; i++) @(negedge clk);
    chk("ack_count", ack_port.size(), n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_memCe", memCe, 0);
    chk("rst_cpuAck", cpuAck, 0);
    chk("rst_cpuRdData", cpuRdData, 0);
    rst = 1;
    // CPU RAM read
    rdData = 32'hDEAD_BEEF;
    access(0, 0, 32'h0000_0010, 0, lat);
    chk("t1_ce_cycles", ce_cnt, 1);
    chk("t1_latency", lat, 2);
    chk("t1_rd", cpuRdData, 32'hDEAD_BEEF);
    // DMA IO write
    access(1, 1, 32'h7000_0004, 32'h0000_00A5, lat);
    chk("t2_ce_cycles", ce_cnt, 4);
    chk("t2_latency", lat, 5);
    chk("t2_dma_rd_unchanged", dmaRdData, 0);
    // Both requesting from reset: strict alternation, acks 3 cycles apart
    @(negedge clk);
    rst = 0;
    rdData = 32'h0BAD_F00D;
    cpuReq = 1; cpuWr = 0; cpuAddr = 32'h0000_0100;
    dmaReq = 1; dmaWr = 0; dmaAddr = 32'h0000_0200;
    @(negedge clk);
    ack_port.delete(); ack_cyc.delete();
    rst = 1;
    wait_acks(4);
    cpuReq = 0; dmaReq = 0;
    if (ack_port.size() >= 4) begin
      chk("t3_order0", ack_port[0], 0);
      chk("t3_order1", ack_port[1], 1);
      chk("t3_order2", ack_port[2], 0);
      chk("t3_order3", ack_port[3], 1);
      chk("t3_gap1", ack_cyc[1] - ack_cyc[0], 3);
      chk("t3_gap3", ack_cyc[3] - ack_cyc[2], 3);
    end
    chk("t3_dma_rd", dmaRdData, 32'h0BAD_F00D);
    // Region boundaries
    access(0, 0, 32'h6FFF_FFFC, 0, lat);
    chk("t4_below_io", ce_cnt, 1);
    access(0, 0, 32'h7FFF_FFFC, 0, lat);
    chk("t4_top_io", ce_cnt, 4);
    access(0, 0, 32'h8000_0000, 0, lat);
    chk("t4_above_io", ce_cnt, 1);
    // Reset during the wait states of an IO access
    @(negedge clk);
    cpuReq = 1; cpuWr = 0; cpuAddr = 32'h7000_0000;
    repeat (3) @(negedge clk);
    ack_port.delete(); ack_cyc.delete();
    #1 rst = 0;
    cpuReq = 0;
    #1;
    chk("t5_ce_abort", memCe, 0);
    chk("t5_addr_abort", memAddr, 0);
    repeat (3) @(negedge clk);
    chk("t5_no_ack", ack_port.size(), 0);
    cpuReq = 1; cpuAddr = 32'h0000_0040;
    dmaReq = 1; dmaWr = 0; dmaAddr = 32'h0000_0080;
    @(negedge clk);
    rst = 1;
    wait_acks(2);
    cpuReq = 0; dmaReq = 0;
    chk("t5_first_cpu", (ack_port.size() > 0) ? ack_port[0] : 9, 0);
    // Address change while busy is ignored
    @(negedge clk);
    ce_cnt = 0;
    rdData = 32'h1234_5678;
    cpuReq = 1; cpuWr = 0; cpuAddr = 32'h7000_0000;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (memCe) chk("t6_addr_hold", memAddr, 32'h7000_0000);
      if (i == 1) cpuAddr = 32'h0000_0000;
      if (cpuAck) begin lat = i; break; end
    end
    cpuReq = 0;
    chk("t6_ce_cycles", ce_cnt, 4);
    chk("t6_latency", lat, 5);
    chk("t6_rd", cpuRdData, 32'h1234_5678);
    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
